dbfs_mul_pipe: RTL and testbench

//  Parametrised pipelined multiplier for the dBFS datapath: signed/unsigned operand mode, configurable depth,

---
 rtl/dbfs_mul_pipe_if.sv | 27 ++
 rtl/dbfs_mul_pipe.sv | 135 +++++++++++++
 tb/tb_dbfs_mul_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dbfs_mul_pipe_if.sv
// Handshake bundle for dbfs_mul_pipe: operand input side, result output side and overflow flag.
// The upstream/downstream side takes the master modport; the multiplier takes the slave modport.
interface dbfs_mul_pipe_if #(
  parameter int A_WIDTH   = 38,
  parameter int B_WIDTH   = 4,
  parameter int OUT_WIDTH = 42
);
  logic                 is_signed;
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   din0;
  logic [B_WIDTH-1:0]   din1;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] dout;
  logic                 ovf;

  modport master (
    output is_signed, in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  is_signed, in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/dbfs_mul_pipe.sv
// dbfs_mul_pipe: pipelined signed/unsigned multiplier with round-half-up right shift, full-stall
// valid/ready flow control and a sticky overflow flag. Define DBFS_MUL_SAT_EN to clamp instead of wrap.
module dbfs_mul_pipe #(
  parameter int A_WIDTH   = 38,
  parameter int B_WIDTH   = 4,
  parameter int OUT_WIDTH = 42,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 2
) (
  input  logic           clk,
  input  logic           reset,
  dbfs_mul_pipe_if.slave bus
);

  localparam int PW = A_WIDTH + B_WIDTH + 2;
  localparam int RW = (PW + 1 > OUT_WIDTH + 1) ? PW + 1 : OUT_WIDTH + 1;
  localparam int PD = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam logic signed [RW-1:0] RND = ({{(RW-1){1'b0}}, 1'b1} << SHIFT) >> 1;

  logic                 advance;
  logic                 take;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;

  assign advance       = ~out_valid_q | bus.out_ready;
  assign take          = bus.in_valid & advance;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;

  logic signed [A_WIDTH:0] a_ext;
  logic signed [B_WIDTH:0] b_ext;
  logic signed [PW-1:0]    p_in;

  // One extra bit per operand lets both modes share a single signed multiplier.
  always_comb begin
    a_ext = bus.is_signed ? {bus.din0[A_WIDTH-1], bus.din0} : {1'b0, bus.din0};
    b_ext = bus.is_signed ? {bus.din1[B_WIDTH-1], bus.din1} : {1'b0, bus.din1};
    p_in  = PW'(a_ext) * PW'(b_ext);
  end

  logic signed [PW-1:0] fin_p;
  logic                 fin_s;
  logic                 fin_v;

  if (NUM_STAGE == 1) begin : g_direct
    assign fin_p = p_in;
    assign fin_s = bus.is_signed;
    assign fin_v = take;
  end else begin : g_pipe
    logic signed [PW-1:0] p_q [PD];
    logic signed [PW-1:0] p_d [PD];
    logic [PD-1:0]        s_q, s_d;
    logic [PD-1:0]        v_q, v_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      p_d = p_q;
      s_d = s_q;
      v_d = v_q;
      if (advance) begin
        p_d[0] = p_in;
        s_d[0] = bus.is_signed;
        v_d[0] = take;
        for (int i = 1; i < PD; i++) begin
          p_d[i] = p_q[i-1];
          s_d[i] = s_q[i-1];
          v_d[i] = v_q[i-1];
        end
      end
    end

    // NOTE: data registers are reset along with valids so dout reads 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < PD; i++) p_q[i] <= '0;
        s_q <= '0;
        v_q <= '0;
      end else begin
        p_q <= p_d;
        s_q <= s_d;
        v_q <= v_d;
      end
    end

    assign fin_p = p_q[PD-1];
    assign fin_s = s_q[PD-1];
    assign fin_v = v_q[PD-1];
  end

  logic signed [RW-1:0]  r_x;
  logic                  oor;
  logic [OUT_WIDTH-1:0]  r_out;

  always_comb begin
    r_x   = (RW'(fin_p) + RND) >>> SHIFT;
    oor   = fin_s ? ~(&r_x[RW-1:OUT_WIDTH-1] | ~|r_x[RW-1:OUT_WIDTH-1])
                  : |r_x[RW-1:OUT_WIDTH];
    r_out = r_x[OUT_WIDTH-1:0];
`ifdef DBFS_MUL_SAT_EN
    // Unsigned products are never negative, so unsigned overflow always clamps high.
    if (oor) begin
      if (fin_s) r_out = r_x[RW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else       r_out = '1;
    end
`endif
  end

  always_comb begin
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (advance) begin
      dout_d      = r_out;
      out_valid_d = fin_v;
      ovf_d       = ovf_q | (fin_v & oor);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_dbfs_mul_pipe.sv
// Directed bench for dbfs_mul_pipe: default build, an 8x8->8 SHIFT=4 single-stage instance
// (wrap or clamp depending on DBFS_MUL_SAT_EN) and an 8x8->16 SHIFT=1 three-stage instance.
module tb_dbfs_mul_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dbfs_mul_pipe_if #(.A_WIDTH(38), .B_WIDTH(4), .OUT_WIDTH(42)) if_def ();
  dbfs_mul_pipe_if #(.A_WIDTH(8),  .B_WIDTH(8), .OUT_WIDTH(8))  if_sat ();
  dbfs_mul_pipe_if #(.A_WIDTH(8),  .B_WIDTH(8), .OUT_WIDTH(16)) if_rnd ();

  dbfs_mul_pipe u_def (.clk(clk), .reset(rst_n), .bus(if_def));
  dbfs_mul_pipe #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8), .SHIFT(4), .NUM_STAGE(1))
    u_sat (.clk(clk), .reset(rst_n), .bus(if_sat));
  dbfs_mul_pipe #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(16), .SHIFT(1), .NUM_STAGE(3))
    u_rnd (.clk(clk), .reset(rst_n), .bus(if_rnd));

  task automatic test_reset();
    if_def.in_valid = 1'b0; if_def.is_signed = 1'b0; if_def.din0 = '0; if_def.din1 = '0; if_def.out_ready = 1'b1;
    if_sat.in_valid = 1'b0; if_sat.is_signed = 1'b0; if_sat.din0 = '0; if_sat.din1 = '0; if_sat.out_ready = 1'b1;
    if_rnd.in_valid = 1'b0; if_rnd.is_signed = 1'b0; if_rnd.din0 = '0; if_rnd.din1 = '0; if_rnd.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if_def.out_valid, if_sat.out_valid, if_rnd.out_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_out_valid got %b want 000", {if_def.out_valid, if_sat.out_valid, if_rnd.out_valid});
    end
    n_cmp++;
    if ({if_def.ovf, if_sat.ovf, if_rnd.ovf} !== 3'b000) begin
      n_err++; $display("FAIL reset_ovf got %b want 000", {if_def.ovf, if_sat.ovf, if_rnd.ovf});
    end
    n_cmp++;
    if ({if_def.in_ready, if_sat.in_ready, if_rnd.in_ready} !== 3'b111) begin
      n_err++; $display("FAIL reset_in_ready got %b want 111", {if_def.in_ready, if_sat.in_ready, if_rnd.in_ready});
    end
    n_cmp++;
    if (if_def.dout !== 42'd0) begin n_err++; $display("FAIL reset_dout_def got %0h want 0", if_def.dout); end
    n_cmp++;
    if (if_sat.dout !== 8'd0) begin n_err++; $display("FAIL reset_dout_sat got %0h want 0", if_sat.dout); end
    n_cmp++;
    if (if_rnd.dout !== 16'd0) begin n_err++; $display("FAIL reset_dout_rnd got %0h want 0", if_rnd.dout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    @(negedge clk);
    if_def.din0 = 38'd1000; if_def.din1 = 4'd7; if_def.is_signed = 1'b0; if_def.in_valid = 1'b1;
    #1;
    n_cmp++;
    if (if_def.in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got %b want 1", if_def.in_ready); end
    @(negedge clk);
    if_def.in_valid = 1'b0;
    n_cmp++;
    if (if_def.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b want 0", if_def.out_valid); end
    @(negedge clk);
    n_cmp++;
    if (if_def.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", if_def.out_valid); end
    n_cmp++;
    if (if_def.dout !== 42'd7000) begin n_err++; $display("FAIL single_dout got %0d want 7000", if_def.dout); end
    n_cmp++;
    if (if_def.ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf got %b want 0", if_def.ovf); end
    @(negedge clk);
    n_cmp++;
    if (if_def.out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop got %b want 0", if_def.out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if_def.out_valid !== (k >= 2 && k < 18)) begin
        n_err++; $display("FAIL stream_valid[%0d] got %b want %b", k, if_def.out_valid, (k >= 2 && k < 18));
      end
      if (k >= 2 && k < 18) begin
        n_cmp++;
        if (if_def.dout !== 42'(3 * (k - 2))) begin
          n_err++; $display("FAIL stream_dout[%0d] got %0d want %0d", k - 2, if_def.dout, 3 * (k - 2));
        end
      end
      if (k < 16) begin
        if_def.in_valid = 1'b1; if_def.din0 = 38'(k); if_def.din1 = 4'd3;
      end else begin
        if_def.in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (if_def.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %b want 1", k, if_def.in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int              snd = 0;
    int              rcv = 0;
    logic            stalled_prev = 1'b0;
    logic            saw_full = 1'b0;
    logic [41:0]     prev_dout = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if_def.out_ready = !(c >= 6 && c < 11);
      if (stalled_prev) begin
        n_cmp++;
        if (if_def.out_valid !== 1'b1 || if_def.dout !== prev_dout) begin
          n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%0d want v=1 d=%0d", c, if_def.out_valid, if_def.dout, prev_dout);
        end
      end
      if (if_def.out_valid && if_def.out_ready) begin
        n_cmp++;
        if (rcv >= 12) begin
          n_err++; $display("FAIL bp_extra got output %0d want none", if_def.dout);
        end else if (if_def.dout !== 42'((100 + rcv) * 5)) begin
          n_err++; $display("FAIL bp_dout[%0d] got %0d want %0d", rcv, if_def.dout, (100 + rcv) * 5);
        end
        rcv++;
      end
      stalled_prev = if_def.out_valid && !if_def.out_ready;
      prev_dout    = if_def.dout;
      if (snd < 12) begin
        if_def.in_valid = 1'b1; if_def.din0 = 38'(100 + snd); if_def.din1 = 4'd5;
      end else begin
        if_def.in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (if_def.in_ready !== (!if_def.out_valid || if_def.out_ready)) begin
        n_err++; $display("FAIL bp_in_ready[%0d] got %b want %b", c, if_def.in_ready, (!if_def.out_valid || if_def.out_ready));
      end
      if (!if_def.in_ready) saw_full = 1'b1;
      if (if_def.in_valid && if_def.in_ready) snd++;
    end
    if_def.out_ready = 1'b1;
    if_def.in_valid  = 1'b0;
    n_cmp++;
    if (rcv != 12) begin n_err++; $display("FAIL bp_count got %0d want 12", rcv); end
    n_cmp++;
    if (saw_full !== 1'b1) begin n_err++; $display("FAIL bp_stall_seen got %b want 1", saw_full); end
  endtask

  task automatic test_saturation();
    logic [7:0] va [8] = '{8'h03, 8'h80, 8'h7F, 8'hFF, 8'h03, 8'hF0, 8'h80, 8'h80};
    logic [7:0] vb [8] = '{8'h05, 8'h7F, 8'h7F, 8'hFF, 8'h05, 8'h01, 8'h02, 8'h02};
    logic       vs [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vo [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef DBFS_MUL_SAT_EN
    logic [7:0] ve [8] = '{8'h01, 8'h80, 8'h7F, 8'hFF, 8'h01, 8'hFF, 8'h10, 8'hF0};
`else
    logic [7:0] ve [8] = '{8'h01, 8'h08, 8'hF0, 8'hE0, 8'h01, 8'hFF, 8'h10, 8'hF0};
`endif
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        n_cmp++;
        if (if_sat.out_valid !== 1'b1 || if_sat.dout !== ve[k-1]) begin
          n_err++; $display("FAIL sat_dout[%0d] got v=%b d=%02h want v=1 d=%02h", k - 1, if_sat.out_valid, if_sat.dout, ve[k-1]);
        end
        n_cmp++;
        if (if_sat.ovf !== vo[k-1]) begin
          n_err++; $display("FAIL sat_ovf[%0d] got %b want %b", k - 1, if_sat.ovf, vo[k-1]);
        end
      end
      if (k < 8) begin
        if_sat.in_valid = 1'b1; if_sat.din0 = va[k]; if_sat.din1 = vb[k]; if_sat.is_signed = vs[k];
      end else begin
        if_sat.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (if_sat.out_valid !== 1'b0) begin n_err++; $display("FAIL sat_valid_drop got %b want 0", if_sat.out_valid); end
  endtask

  task automatic test_rounding();
    logic [7:0]  va [5] = '{8'h03, 8'h01, 8'hFD, 8'hFF, 8'h05};
    logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] ve [5] = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0000, 16'h0003};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if_rnd.out_valid !== (k >= 3 && k < 8)) begin
        n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", k, if_rnd.out_valid, (k >= 3 && k < 8));
      end
      if (k >= 3 && k < 8) begin
        n_cmp++;
        if (if_rnd.dout !== ve[k-3]) begin
          n_err++; $display("FAIL rnd_dout[%0d] got %04h want %04h", k - 3, if_rnd.dout, ve[k-3]);
        end
      end
      if (k < 5) begin
        if_rnd.in_valid = 1'b1; if_rnd.din0 = va[k]; if_rnd.din1 = 8'h01; if_rnd.is_signed = vs[k];
      end else begin
        if_rnd.in_valid = 1'b0;
      end
    end
    n_cmp++;
    if (if_rnd.ovf !== 1'b0) begin n_err++; $display("FAIL rnd_ovf got %b want 0", if_rnd.ovf); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    if_def.in_valid = 1'b1; if_def.din0 = 38'd11; if_def.din1 = 4'd2; if_def.is_signed = 1'b0;
    @(negedge clk);
    if_def.din0 = 38'd12;
    @(negedge clk);
    if_def.in_valid = 1'b0;
    n_cmp++;
    if (if_def.out_valid !== 1'b1 || if_def.dout !== 42'd22) begin
      n_err++; $display("FAIL mid_pre_reset got v=%b d=%0d want v=1 d=22", if_def.out_valid, if_def.dout);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if_def.out_valid !== 1'b0 || if_def.dout !== 42'd0 || if_def.ovf !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_def got v=%b d=%0d o=%b want v=0 d=0 o=0", if_def.out_valid, if_def.dout, if_def.ovf);
    end
    n_cmp++;
    if (if_sat.ovf !== 1'b0) begin n_err++; $display("FAIL mid_reset_sat_ovf got %b want 0", if_sat.ovf); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if_def.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_release_valid[%0d] got %b want 0", k, if_def.out_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_rounding();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
